fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 13 +
 rtl/next_pc_sel.sv | 30 +++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    localparam logic [1:0] BS_SEQ  = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JREG = 2'b10;
    localparam logic [1:0] BS_BR   = 2'b11;

    localparam logic [15:0] RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/next_pc_sel.sv
// Branch decision and redirect target selection for the fetch controller.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [1:0]  bs,
    input  logic        ps,
    input  logic        z,
    input  logic [15:0] bra,
    input  logic [15:0] raa,
    output logic        redirect,
    output logic [15:0] target
);

    always_comb begin
        redirect = 1'b0;
        target   = bra;
        case (bs)
            BS_SEQ:  redirect = 1'b0;
            // PS=0 takes the branch on Z=1, PS=1 takes it on Z=0
            BS_COND: redirect = z ^ ps;
            BS_JREG: begin
                redirect = 1'b1;
                target   = raa;
            end
            BS_BR:   redirect = 1'b1;
            default: redirect = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, branch redirect, memory request
// handshake and a one-entry skid buffer for decode stalls.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  BS,
    input  logic        PS,
    input  logic        Z,
    input  logic [15:0] BrA,
    input  logic [15:0] RAA,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] IR,
    output logic        IR_valid,
    output logic [15:0] PC,
    output logic [15:0] PC1,
    output logic        flush
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc1_q, pc1_d;
    logic [15:0] old_addr_q, old_addr_d;
    logic [15:0] skid_pc1_q, skid_pc1_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] skid_ir_q, skid_ir_d;
    logic        irv_q, irv_d;
    logic        flush_q, flush_d;
    logic        redirect;
    logic [15:0] target;
    logic [15:0] pc_inc;

    next_pc_sel u_next_pc_sel (
        .bs       (BS),
        .ps       (PS),
        .z        (Z),
        .bra      (BrA),
        .raa      (RAA),
        .redirect (redirect),
        .target   (target)
    );

    assign pc_inc = pc_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            pc1_q      <= 16'h0000;
            old_addr_q <= 16'h0000;
            skid_pc1_q <= 16'h0000;
            ir_q       <= 32'h0;
            skid_ir_q  <= 32'h0;
            irv_q      <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc1_q      <= pc1_d;
            old_addr_q <= old_addr_d;
            skid_pc1_q <= skid_pc1_d;
            ir_q       <= ir_d;
            skid_ir_q  <= skid_ir_d;
            irv_q      <= irv_d;
            flush_q    <= flush_d;
        end
    end

    // The skid buffer holds a live entry exactly while in HOLD.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc1_d      = pc1_q;
        old_addr_d = old_addr_q;
        skid_pc1_d = skid_pc1_q;
        ir_d       = ir_q;
        skid_ir_d  = skid_ir_q;
        irv_d      = irv_q;
        flush_d    = 1'b0;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d    = target;
                    irv_d   = 1'b0;
                    flush_d = 1'b1;
                    if (!imem_ack) begin
                        old_addr_d = pc_q;
                        state_d    = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (stall && irv_q) begin
                        skid_ir_d  = imem_data;
                        skid_pc1_d = pc_inc;
                        state_d    = HOLD;
                    end else begin
                        ir_d  = imem_data;
                        irv_d = 1'b1;
                        pc1_d = pc_inc;
                    end
                end else if (!stall) begin
                    irv_d = 1'b0;
                end
            end
            DRAIN: begin
                // Keep presenting the abandoned address until memory answers it.
                imem_req  = 1'b1;
                imem_addr = old_addr_q;
                if (redirect) begin
                    pc_d    = target;
                    irv_d   = 1'b0;
                    flush_d = 1'b1;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d       = target;
                    irv_d      = 1'b0;
                    flush_d    = 1'b1;
                    skid_ir_d  = 32'h0;
                    skid_pc1_d = 16'h0000;
                    state_d    = FETCH;
                end else if (!stall) begin
                    ir_d    = skid_ir_q;
                    pc1_d   = skid_pc1_q;
                    irv_d   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign IR       = ir_q;
    assign IR_valid = irv_q;
    assign PC       = pc_q;
    assign PC1      = pc1_q;
    assign flush    = flush_q;

endmodule
